// File: rtl/base_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package base_arb_pkg;

  // Arbiter FSM: IDLE has no holder, BUSY has exactly one holder.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width of a binary index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/base_prienc_hp.sv
// Priority encoder, index 0 highest priority, one-hot result.
module base_prienc_hp #(
  parameter int n = 4
) (
  input  logic [0:n-1] vec,
  output logic [0:n-1] onehot,
  output logic         any
);

  // Scan from the lowest-priority end so the lowest set index wins last.
  always_comb begin
    onehot = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/base_rrarb.sv
// Round-robin arbiter with optional maximum grant tenure.
// Handshake: gnt/gnt_v act as a valid with no ready; the holder keeps the
// grant until it pulses rel, drops its req bit, or the tenure limit expires.
module base_rrarb
  import base_arb_pkg::*;
#(
  parameter int ways     = 4,
  parameter int max_hold = 0,
  localparam int iw      = idx_w(ways)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:ways-1] req,
  input  logic          rel,
  output logic [0:ways-1] gnt,
  output logic          gnt_v,
  output logic [iw-1:0] gnt_id,
  output logic          preempt,
  output state_t        dbg_state
);

  state_t          state;
  logic [iw-1:0]   ptr;
  logic [iw-1:0]   ptr_nxt;
  logic [iw-1:0]   mask_ptr;
  logic [0:ways-1] cand;
  logic [0:ways-1] mask_ge_ptr;
  logic [0:ways-1] masked;
  logic [0:ways-1] win_m;
  logic [0:ways-1] win_f;
  logic [0:ways-1] winner;
  logic [iw-1:0]   win_id;
  logic            any_m;
  logic            any_f;
  logic            holder_req;
  logic            hold_hit;
  logic            release_now;

  assign dbg_state = state;

  // Holder still requesting, and the rotating pointer after it lets go.
  assign holder_req  = |(req & gnt);
  assign ptr_nxt     = (gnt_id == iw'(ways - 1)) ? '0 : gnt_id + 1'b1;
  assign release_now = (state == BUSY) && (rel || !holder_req || hold_hit);

  // Tenure counter only exists when a hold limit is configured.
  generate
    if (max_hold > 0) begin : g_hold
      localparam int hw = $clog2(max_hold + 1);
      logic [hw-1:0] hold_cnt;

      assign hold_hit = (hold_cnt == hw'(max_hold - 1));

      // Count BUSY cycles of the current holder; clear on any handover.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_cnt <= '0;
        end else if (state == BUSY && !release_now) begin
          if (hold_cnt != hw'(max_hold)) hold_cnt <= hold_cnt + 1'b1;
        end else begin
          hold_cnt <= '0;
        end
      end
    end else begin : g_nohold
      assign hold_hit = 1'b0;
    end
  endgenerate

  // Candidates and the pointer the search starts from this cycle.
  always_comb begin
    cand     = '0;
    mask_ptr = ptr;
    if (state == IDLE) begin
      cand = req;
    end else if (release_now) begin
      cand     = req & ~gnt;
      mask_ptr = ptr_nxt;
    end
    for (int i = 0; i < ways; i++) begin
      mask_ge_ptr[i] = (i >= int'(mask_ptr));
    end
  end

  assign masked = cand & mask_ge_ptr;

  base_prienc_hp #(.n(ways)) u_masked (
    .vec    (masked),
    .onehot (win_m),
    .any    (any_m)
  );

  base_prienc_hp #(.n(ways)) u_full (
    .vec    (cand),
    .onehot (win_f),
    .any    (any_f)
  );

  assign winner = any_m ? win_m : win_f;

  // One-hot winner to binary index.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < ways; i++) begin
      if (winner[i]) win_id = win_id | iw'(i);
    end
  end

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_v   <= 1'b0;
      gnt_id  <= '0;
      preempt <= 1'b0;
      ptr     <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (any_f) begin
            gnt    <= winner;
            gnt_v  <= 1'b1;
            gnt_id <= win_id;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr     <= ptr_nxt;
            preempt <= hold_hit && !rel && holder_req;
            if (any_f) begin
              gnt    <= winner;
              gnt_v  <= 1'b1;
              gnt_id <= win_id;
            end else begin
              gnt    <= '0;
              gnt_v  <= 1'b0;
              gnt_id <= '0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_base_rrarb.sv
// Directed bench for base_rrarb. Vectors are written leftmost bit = requester 0.
module tb_base_rrarb;
  import base_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // u0: ways=4, unlimited tenure
  logic [0:3] req0 = '0;
  logic       rel0 = 1'b0;
  logic [0:3] gnt0;
  logic       gv0;
  logic [1:0] gid0;
  logic       pre0;
  state_t     st0;

  // u1: ways=4, max_hold=3
  logic [0:3] req1 = '0;
  logic       rel1 = 1'b0;
  logic [0:3] gnt1;
  logic       gv1;
  logic [1:0] gid1;
  logic       pre1;
  state_t     st1;

  // u2: ways=1
  logic [0:0] req2 = '0;
  logic       rel2 = 1'b0;
  logic [0:0] gnt2;
  logic       gv2;
  logic [0:0] gid2;
  logic       pre2;
  state_t     st2;

  base_rrarb #(.ways(4), .max_hold(0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .rel(rel0), .gnt(gnt0),
    .gnt_v(gv0), .gnt_id(gid0), .preempt(pre0), .dbg_state(st0));

  base_rrarb #(.ways(4), .max_hold(3)) u1 (
    .clk(clk), .reset(reset), .req(req1), .rel(rel1), .gnt(gnt1),
    .gnt_v(gv1), .gnt_id(gid1), .preempt(pre1), .dbg_state(st1));

  base_rrarb #(.ways(1), .max_hold(0)) u2 (
    .clk(clk), .reset(reset), .req(req2), .rel(rel2), .gnt(gnt2),
    .gnt_v(gv2), .gnt_id(gid2), .preempt(pre2), .dbg_state(st2));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_g;
  logic [1:0] exp_id;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("rst_gnt0", 32'(gnt0), 32'h0);
    check("rst_gv0", 32'(gv0), 32'h0);
    check("rst_gid0", 32'(gid0), 32'h0);
    check("rst_pre0", 32'(pre0), 32'h0);
    check("rst_st0", 32'(st0), 32'(IDLE));
    #2 reset = 1'b0;

    // Rotation with the holder dropping each cycle: 1000,0100,0010,0001,1000.
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    req0 = 4'b1111;
    tick();
    exp_id = 2'd0;
    exp_g = exp_q.pop_front();
    check("rot_gnt", 32'(gnt0), 32'(exp_g));
    check("rot_gid", 32'(gid0), 32'(exp_id));
    check("rot_gv", 32'(gv0), 32'h1);
    req0 = 4'b0111; tick();
    exp_id = 2'd1; exp_g = exp_q.pop_front();
    check("rot_gnt", 32'(gnt0), 32'(exp_g));
    check("rot_gid", 32'(gid0), 32'(exp_id));
    check("rot_gv", 32'(gv0), 32'h1);
    req0 = 4'b1011; tick();
    exp_id = 2'd2; exp_g = exp_q.pop_front();
    check("rot_gnt", 32'(gnt0), 32'(exp_g));
    check("rot_gid", 32'(gid0), 32'(exp_id));
    check("rot_gv", 32'(gv0), 32'h1);
    req0 = 4'b1101; tick();
    exp_id = 2'd3; exp_g = exp_q.pop_front();
    check("rot_gnt", 32'(gnt0), 32'(exp_g));
    check("rot_gid", 32'(gid0), 32'(exp_id));
    check("rot_gv", 32'(gv0), 32'h1);
    req0 = 4'b1110; tick();
    exp_id = 2'd0; exp_g = exp_q.pop_front();
    check("rot_gnt", 32'(gnt0), 32'(exp_g));
    check("rot_gid", 32'(gid0), 32'(exp_id));
    check("rot_gv", 32'(gv0), 32'h1);
    req0 = 4'b0000; tick();
    check("rot_end_gnt", 32'(gnt0), 32'h0);
    check("rot_end_st", 32'(st0), 32'(IDLE));

    // Single requester 2: grant after one cycle, then back to IDLE.
    pulse_reset();
    req0 = 4'b0010; tick();
    check("single_gnt", 32'(gnt0), 32'(4'b0010));
    check("single_gid", 32'(gid0), 32'd2);
    check("single_st", 32'(st0), 32'(BUSY));
    req0 = 4'b0000; tick();
    check("drop_gnt", 32'(gnt0), 32'h0);
    check("drop_gv", 32'(gv0), 32'h0);
    check("drop_gid", 32'(gid0), 32'h0);
    check("drop_st", 32'(st0), 32'(IDLE));
    rel0 = 1'b1; tick(); rel0 = 1'b0;
    check("idle_rel_gnt", 32'(gnt0), 32'h0);

    // Holder 2 releases via rel while 3 waits: 0001, then 1000.
    pulse_reset();
    req0 = 4'b0010; tick();
    check("h2_gnt", 32'(gnt0), 32'(4'b0010));
    req0 = 4'b0011; rel0 = 1'b1; tick(); rel0 = 1'b0;
    check("rel_gnt", 32'(gnt0), 32'(4'b0001));
    check("rel_gid", 32'(gid0), 32'd3);
    check("rel_pre", 32'(pre0), 32'h0);
    req0 = 4'b1001; tick();
    check("nonholder_gnt", 32'(gnt0), 32'(4'b0001));
    req0 = 4'b1000; tick();
    check("wrap_gnt", 32'(gnt0), 32'(4'b1000));
    check("wrap_gid", 32'(gid0), 32'd0);

    // Asynchronous reset mid-grant, then restart from ptr=0.
    pulse_reset();
    req0 = 4'b0100; tick();
    check("pre_rst_gnt", 32'(gnt0), 32'(4'b0100));
    reset = 1'b1;
    #2;
    check("async_gnt", 32'(gnt0), 32'h0);
    check("async_gv", 32'(gv0), 32'h0);
    check("async_pre", 32'(pre0), 32'h0);
    reset = 1'b0;
    req0 = 4'b0101; tick();
    check("post_rst_gnt", 32'(gnt0), 32'(4'b0100));
    check("post_rst_gid", 32'(gid0), 32'd1);
    req0 = 4'b0000;

    // max_hold=3: three cycles for requester 0, then forced handover.
    pulse_reset();
    req1 = 4'b1100;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_gnt", 32'(gnt1), 32'(4'b1000));
      check("hold_pre", 32'(pre1), 32'h0);
    end
    tick();
    check("preempt_gnt", 32'(gnt1), 32'(4'b0100));
    check("preempt_pulse", 32'(pre1), 32'h1);
    tick();
    check("preempt_end", 32'(pre1), 32'h0);
    check("hold2_gnt", 32'(gnt1), 32'(4'b0100));
    tick();
    check("hold3_gnt", 32'(gnt1), 32'(4'b0100));
    rel1 = 1'b1; tick(); rel1 = 1'b0;
    check("coincide_gnt", 32'(gnt1), 32'(4'b1000));
    check("coincide_pre", 32'(pre1), 32'h0);
    req1 = 4'b0000;

    // ways=1: grant, release to one IDLE cycle, grant again.
    pulse_reset();
    req2 = 1'b1; tick();
    check("w1_gnt_a", 32'(gnt2), 32'h1);
    check("w1_gid", 32'(gid2), 32'h0);
    rel2 = 1'b1; tick(); rel2 = 1'b0;
    check("w1_idle", 32'(gnt2), 32'h0);
    check("w1_idle_st", 32'(st2), 32'(IDLE));
    tick();
    check("w1_gnt_b", 32'(gnt2), 32'h1);
    check("w1_gv", 32'(gv2), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
